// File: rtl/fwd_scoreboard_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fwd_scoreboard_if                                                |
// | Brief   : Issue / source-operand / bypass-select bundle for fwd_scoreboard |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface fwd_scoreboard_if #(
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 3,
   parameter int REG_AW  = 5,
   parameter int LAT_W   = 2
);
   localparam int SELW = $clog2(DEPTH + 1);

   logic                      issue_valid_i;
   logic [REG_AW-1:0]         issue_rd_i;
   logic [LAT_W-1:0]          issue_lat_i;
   logic [NUM_SRC-1:0]        src_valid_i;
   logic [NUM_SRC*REG_AW-1:0] src_addr_i;
   logic                      flush_i;
   logic [NUM_SRC*SELW-1:0]   fwd_sel_o;
   logic                      stall_o;

   modport master (
      output issue_valid_i, issue_rd_i, issue_lat_i, src_valid_i, src_addr_i, flush_i,
      input  fwd_sel_o, stall_o
   );

   modport slave (
      input  issue_valid_i, issue_rd_i, issue_lat_i, src_valid_i, src_addr_i, flush_i,
      output fwd_sel_o, stall_o
   );
endinterface
`default_nettype wire

// File: rtl/fwd_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fwd_scoreboard                                                   |
// | Brief   : Operand-forwarding select and hazard-stall unit with a DEPTH-slot|
// |           writer tracker behind EX. FWD_LAT_STALL_EN enables latency-aware |
// |           stalling; without it every producer forwards from slot 1.        |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module fwd_scoreboard #(
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 3,
   parameter int REG_AW  = 5,
   parameter int LAT_W   = 2
) (
   input  wire             clk_i,
   input  wire             rst_n_i,
   fwd_scoreboard_if.slave bus
);
   localparam int SELW = $clog2(DEPTH + 1);

   logic [DEPTH:1]          r_vld;
   logic [REG_AW-1:0]       r_rd [1:DEPTH];
   logic                    w_load;
   logic                    w_stall;
   logic [NUM_SRC-1:0]      w_found;
   logic [NUM_SRC-1:0]      w_pend;
   logic [NUM_SRC*SELW-1:0] w_sel;

   // Writes to x0 never enter the tracker, so x0 can never be forwarded.
   assign w_load = bus.issue_valid_i & ~w_stall & ~bus.flush_i & (bus.issue_rd_i != '0);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_vld <= '0;
      end else begin
         r_vld[1] <= w_load;
         for (int k = 2; k <= DEPTH; k++) r_vld[k] <= r_vld[k-1];
      end
   end

   always_ff @(posedge clk_i) begin
      r_rd[1] <= bus.issue_rd_i;
      for (int k = 2; k <= DEPTH; k++) r_rd[k] <= r_rd[k-1];
   end

`ifdef FWD_LAT_STALL_EN
   logic [LAT_W-1:0] r_lat [1:DEPTH];
   logic [LAT_W-1:0] w_issue_lat;

   always_comb begin
      w_issue_lat = bus.issue_lat_i;
      if (bus.issue_lat_i == '0)
         w_issue_lat = LAT_W'(1);
      else if (int'(bus.issue_lat_i) > DEPTH)
         w_issue_lat = LAT_W'(DEPTH);
   end

   always_ff @(posedge clk_i) begin
      r_lat[1] <= w_issue_lat;
      for (int k = 2; k <= DEPTH; k++) r_lat[k] <= r_lat[k-1];
   end
`else
   logic [LAT_W-1:0] w_unused_lat;
   assign w_unused_lat = bus.issue_lat_i;
`endif

   // Scan from slot 1 upward so the first hit is the youngest producer.
   always_comb begin
      w_found = '0;
      w_pend  = '0;
      w_sel   = '0;
      for (int n = 0; n < NUM_SRC; n++) begin
         for (int k = 1; k <= DEPTH; k++) begin
            if (!w_found[n] && bus.src_valid_i[n] && r_vld[k] &&
                (r_rd[k] == bus.src_addr_i[n*REG_AW +: REG_AW]) &&
                (bus.src_addr_i[n*REG_AW +: REG_AW] != '0)) begin
               w_found[n] = 1'b1;
`ifdef FWD_LAT_STALL_EN
               if (int'(r_lat[k]) > k)
                  w_pend[n] = 1'b1;
               else
                  w_sel[n*SELW +: SELW] = SELW'(k);
`else
               w_sel[n*SELW +: SELW] = SELW'(k);
`endif
            end
         end
      end
   end

`ifdef FWD_LAT_STALL_EN
   assign w_stall = |w_pend;
`else
   assign w_stall = 1'b0;
`endif

   assign bus.fwd_sel_o = w_sel;
   assign bus.stall_o   = w_stall;
endmodule
`default_nettype wire

// File: tb/tb_fwd_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_fwd_scoreboard                                                |
// | Brief   : Directed self-checking bench for fwd_scoreboard (both builds of  |
// |           FWD_LAT_STALL_EN).                                               |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_fwd_scoreboard;
   localparam int NUM_SRC = 2;
   localparam int DEPTH   = 3;
   localparam int REG_AW  = 5;
   localparam int LAT_W   = 2;
   localparam int SELW    = $clog2(DEPTH + 1);
`ifdef FWD_LAT_STALL_EN
   localparam bit c_lat_en = 1'b1;
`else
   localparam bit c_lat_en = 1'b0;
`endif

   logic clk_i;
   logic rst_n_i;
   int   n_chk;
   int   n_err;

   fwd_scoreboard_if #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .REG_AW(REG_AW), .LAT_W(LAT_W)) bus_if ();

   fwd_scoreboard #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .REG_AW(REG_AW), .LAT_W(LAT_W)) u_dut (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .bus     (bus_if)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int sel(input int n);
      return int'(bus_if.fwd_sel_o[n*SELW +: SELW]);
   endfunction

   task automatic issue(input bit v, input int rd, input int lat, input bit fl);
      bus_if.issue_valid_i = v;
      bus_if.issue_rd_i    = REG_AW'(rd);
      bus_if.issue_lat_i   = LAT_W'(lat);
      bus_if.flush_i       = fl;
   endtask

   task automatic set_src(input logic [1:0] v, input int a0, input int a1);
      bus_if.src_valid_i = v;
      bus_if.src_addr_i  = {REG_AW'(a1), REG_AW'(a0)};
   endtask

   // Advance to just after the next rising edge; inputs change here.
   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      issue(0, 0, 0, 0);
      set_src(2'b00, 0, 0);
      repeat (DEPTH + 1) cyc();
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst_n_i = 1'b0;
      issue(0, 0, 0, 0);
      set_src(2'b11, 1, 1);

      // Reset held
      repeat (2) @(posedge clk_i);
      #2;
      check("rst_sel0", sel(0), 0);
      check("rst_sel1", sel(1), 0);
      check("rst_stall", int'(bus_if.stall_o), 0);
      rst_n_i = 1'b1;
      cyc();
      #1;
      check("post_rst_sel0", sel(0), 0);
      check("post_rst_stall", int'(bus_if.stall_o), 0);
      idle();

      // Single-cycle producer walks through all slots
      issue(1, 5, 1, 0); set_src(2'b00, 0, 0); cyc();
      issue(0, 0, 0, 0); set_src(2'b01, 5, 0); #1;
      check("x5_t1_sel", sel(0), 1);
      check("x5_t1_stall", int'(bus_if.stall_o), 0);
      cyc(); #1; check("x5_t2_sel", sel(0), 2);
      cyc(); #1; check("x5_t3_sel", sel(0), 3);
      cyc(); #1; check("x5_t4_sel", sel(0), 0);
      idle();

      // Load-use: x7 lat 2, dependent writes x8
      issue(1, 7, 2, 0); set_src(2'b00, 0, 0); cyc();
      issue(1, 8, 1, 0); set_src(2'b11, 8, 7); #1;
      check("ld_t1_stall", int'(bus_if.stall_o), c_lat_en ? 1 : 0);
      check("ld_t1_sel1", sel(1), c_lat_en ? 0 : 1);
      cyc(); #1;
      check("ld_t2_stall", int'(bus_if.stall_o), 0);
      check("ld_t2_sel1", sel(1), 2);
      check("ld_t2_bubble", sel(0), c_lat_en ? 0 : 1);
      cyc();
      issue(0, 0, 0, 0); #1;
      check("ld_t3_sel0", sel(0), 1);
      idle();

      // Back-to-back writers to x3: youngest wins
      issue(1, 3, 1, 0); cyc();
      issue(1, 3, 1, 0); cyc();
      issue(0, 0, 0, 0); set_src(2'b01, 3, 0); #1;
      check("young_sel0", sel(0), 1);
      idle();

      // x0 writer never tracked
      issue(1, 0, 1, 0); cyc();
      issue(0, 0, 0, 0); set_src(2'b01, 0, 0); #1;
      check("x0_sel", sel(0), 0);
      check("x0_stall", int'(bus_if.stall_o), 0);
      idle();

      // Operand not read: no select, no stall even if pending
      issue(1, 6, 2, 0); cyc();
      issue(0, 0, 0, 0); set_src(2'b00, 6, 6); #1;
      check("noread_sel0", sel(0), 0);
      check("noread_stall", int'(bus_if.stall_o), 0);
      idle();

      // Flushed writer never matches
      issue(1, 9, 1, 1); cyc();
      issue(0, 0, 0, 0); set_src(2'b01, 9, 0); #1;
      check("flush_t1_sel", sel(0), 0);
      cyc(); #1;
      check("flush_t2_sel", sel(0), 0);
      idle();

      // Latency 0 behaves as 1
      issue(1, 10, 0, 0); cyc();
      issue(0, 0, 0, 0); set_src(2'b01, 10, 0); #1;
      check("lat0_sel", sel(0), 1);
      check("lat0_stall", int'(bus_if.stall_o), 0);
      idle();

      // Two operands: x12 lat 3 younger than x13 lat 1
      issue(1, 13, 1, 0); cyc();
      issue(1, 12, 3, 0); cyc();
      issue(0, 0, 0, 0); set_src(2'b11, 12, 13); #1;
      check("dual_t2_stall", int'(bus_if.stall_o), c_lat_en ? 1 : 0);
      check("dual_t2_sel0", sel(0), c_lat_en ? 0 : 1);
      check("dual_t2_sel1", sel(1), 2);
      cyc(); #1;
      check("dual_t3_stall", int'(bus_if.stall_o), c_lat_en ? 1 : 0);
      check("dual_t3_sel0", sel(0), c_lat_en ? 0 : 2);
      check("dual_t3_sel1", sel(1), 3);
      cyc(); #1;
      check("dual_t4_stall", int'(bus_if.stall_o), 0);
      check("dual_t4_sel0", sel(0), 3);
      check("dual_t4_sel1", sel(1), 0);
      idle();

      // Asynchronous reset discards in-flight writers immediately
      issue(1, 11, 1, 0); cyc();
      issue(0, 0, 0, 0); set_src(2'b01, 11, 0); #1;
      check("arst_pre_sel", sel(0), 1);
      rst_n_i = 1'b0; #1;
      check("arst_sel", sel(0), 0);
      cyc();
      rst_n_i = 1'b1;
      cyc(); #1;
      check("arst_after_sel", sel(0), 0);
      check("arst_after_stall", int'(bus_if.stall_o), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
